// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encodings and default frame parameters
package uart_pkg;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_DATA_BITS    = 8;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronises the serial input and deserialises 8N1 frames
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    rx_state_t            r_state, w_state;
    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [BW-1:0]        r_bits, w_bits;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_valid, w_valid;
    logic                 w_rx, w_half, w_end;
    assign w_rx    = r_sync[1];
    assign w_half  = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign w_end   = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign o_valid = r_valid;
    assign o_data  = r_shift;
    // next state: detect start edge, confirm at start midpoint, then sample one bit period apart
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bits  = r_bits;
        w_shift = r_shift;
        w_valid = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt = '0;
                if (r_prev && !w_rx) w_state = RX_START;
            end
            RX_START: if (w_half) begin
                w_cnt   = '0;
                w_bits  = '0;
                w_state = w_rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_end) begin
                w_cnt   = '0;
                w_shift = {w_rx, r_shift[DATA_BITS-1:1]};
                w_bits  = r_bits + 1'b1;
                if (w_bits == BW'(DATA_BITS)) w_state = RX_STOP;
            end
            RX_STOP: if (w_end) begin
                w_cnt   = '0;
                w_valid = w_rx;
                w_state = RX_IDLE;
            end
            default: w_state = RX_IDLE;
        endcase
    end
    // synchroniser, edge history and receive state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= w_rx;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bits  <= w_bits;
            r_shift <= w_shift;
            r_valid <= w_valid;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per frame as start, LSB-first data, stop
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_full,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_take,
    output logic                 o_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    tx_state_t            r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [BW-1:0]        r_bits, w_bits;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 w_end;
    assign w_end  = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign o_take = r_state == TX_IDLE && i_full;
    assign o_tx   = r_tx;
    // next state and next line level, so the output flop tracks the state it enters
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bits  = r_bits;
        w_shift = r_shift;
        case (r_state)
            TX_IDLE: begin
                w_cnt  = '0;
                w_bits = '0;
                if (i_full) begin
                    w_state = TX_START;
                    w_shift = i_data;
                end
            end
            TX_START: if (w_end) begin
                w_cnt   = '0;
                w_state = TX_DATA;
            end
            TX_DATA: if (w_end) begin
                w_cnt   = '0;
                w_shift = r_shift >> 1;
                w_bits  = r_bits + 1'b1;
                if (w_bits == BW'(DATA_BITS)) w_state = TX_STOP;
            end
            TX_STOP: if (w_end) begin
                w_cnt   = '0;
                w_state = TX_IDLE;
            end
            default: w_state = TX_IDLE;
        endcase
        w_tx = w_state == TX_START ? 1'b0 : w_state == TX_DATA ? w_shift[0] : 1'b1;
    end
    // transmit state registers and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bits  <= w_bits;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end
endmodule

// File: rtl/uart_top.sv
// uart_top: 8N1 echo, every good received byte is retransmitted through a one-byte holding register
module uart_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_t,
    output logic tx_t
);
    logic                 w_rx_valid, w_take;
    logic [DATA_BITS-1:0] w_rx_data;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_full;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) u_rx (
        .clk(clk), .rst(rst), .i_rx(rx_t), .o_valid(w_rx_valid), .o_data(w_rx_data)
    );
    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) u_tx (
        .clk(clk), .rst(rst), .i_full(r_full), .i_data(r_hold), .o_take(w_take), .o_tx(tx_t)
    );
    // holding register: a same-cycle take frees the slot so the new byte still lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_hold <= '0;
        end else if (w_rx_valid && (!r_full || w_take)) begin
            r_full <= 1'b1;
            r_hold <= w_rx_data;
        end else if (w_take) begin
            r_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: drives serial frames and decodes tx_t against a frame-level byte-list reference
module tb_uart_top;
    localparam int CPB  = 4;
    localparam int FL   = 10 * CPB;
    localparam int MAXC = 8000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_t = 1'b1;
    logic tx_t;
    int cyc = 0;
    logic txl [0:MAXC-1];
    int vectors = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];
    int starts[$];
    uart_top #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_t(rx_t), .tx_t(tx_t)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < MAXC) txl[cyc] = tx_t;
    task automatic check(input string tag, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_t = i == 0 ? 1'b0 : i == 9 ? stop : b[i-1];
            repeat (CPB) @(negedge clk);
        end
        rx_t = 1'b1;
    endtask
    task automatic scan(input int from, input int to);
        int t;
        int bad;
        logic [7:0] b;
        t = from;
        while (t + FL <= to) begin
            if (txl[t] == 1'b0 && txl[t-1] == 1'b1) begin
                for (int j = 0; j < 8; j++) b[j] = txl[t + CPB * (j + 1) + CPB / 2];
                bad = 0;
                for (int k = 0; k < FL; k++)
                    if (txl[t+k] != (k < CPB ? 1'b0 : k >= 9 * CPB ? 1'b1 : b[k/CPB-1])) bad++;
                check("frame_shape", bad, 0);
                got_q.push_back(int'(b));
                starts.push_back(t);
                t += FL;
            end else begin
                t++;
            end
        end
    endtask
    task automatic compare(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        starts.delete();
    endtask
    task automatic count_low(input string tag, input int from, input int to);
        int z;
        z = 0;
        for (int i = from; i < to; i++) if (txl[i] != 1'b1) z++;
        check(tag, z, 0);
    endtask
    initial begin
        int t0, w0, f;
        logic [7:0] b;
        logic ok;
        idle(3);
        check("reset_tx", tx_t, 1);
        rst = 1'b0;
        w0 = cyc;
        idle(100);
        count_low("idle_tx_high", w0, cyc);
        scan(w0, cyc);
        compare("idle");
        w0 = cyc;
        send(8'hA5, 1'b1, t0);
        exp_q.push_back(8'hA5);
        idle(60);
        scan(w0, cyc);
        if (starts.size() > 0)
            check("a5_latency_in_window",
                  int'(starts[0] - t0 >= 9 * CPB + CPB / 2 + 2 && starts[0] - t0 <= 10 * CPB + CPB / 2 + 4), 1);
        compare("a5");
        w0 = cyc;
        rx_t = 1'b0;
        idle(1);
        rx_t = 1'b1;
        idle(80);
        count_low("glitch_tx_high", w0, cyc);
        scan(w0, cyc);
        compare("glitch");
        w0 = cyc;
        send(8'h3C, 1'b0, t0);
        idle(8);
        send(8'h0F, 1'b1, t0);
        exp_q.push_back(8'h0F);
        idle(60);
        scan(w0, cyc);
        compare("framing");
        w0 = cyc;
        send(8'h00, 1'b1, t0);
        send(8'hFF, 1'b1, t0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        idle(70);
        scan(w0, cyc);
        if (starts.size() > 1) check("b2b_spacing_ge_frame", int'(starts[1] - starts[0] >= FL), 1);
        compare("b2b");
        send(8'h55, 1'b1, t0);
        f = 0;
        while (tx_t !== 1'b0 && f < 100) begin
            @(negedge clk);
            f++;
        end
        check("rst55_started", int'(f < 100), 1);
        idle(4 * CPB + 1);
        check("rst55_bit3", tx_t, 0);
        rst = 1'b1;
        idle(1);
        check("rst55_tx_high", tx_t, 1);
        rst = 1'b0;
        w0 = cyc;
        idle(60);
        count_low("rst55_no_tail", w0, cyc);
        w0 = cyc;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            ok = $urandom_range(4) != 0;
            send(b, ok, t0);
            if (ok) exp_q.push_back(int'(b));
            idle($urandom_range(12, 4));
        end
        idle(70);
        scan(w0, cyc);
        compare("rand");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
